sc_popcount_collect: RTL and testbench

- Downstream consumer of the CAPE stochastic number generators (plain and early-terminated variants) once their Xs streams have passed through the SC arithmetic.
- Counts the 1s on each of NUM_LANES stochastic bitstreams over one stream period.
- Closes the period on the generator's registered done pulse and applies the early-termination rescale (left shift).
- Presents one binary result vector per period on a valid/ready handshake.

---
 rtl/sc_popcount_collect_if.sv | 18 +
 rtl/sc_popcount_collect.sv | 123 ++++++++++++
 tb/tb_sc_popcount_collect.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/sc_popcount_collect_if.sv
// rtl/sc_popcount_collect_if.sv - result stream bundle for sc_popcount_collect (res_len only with SC_COLLECT_LEN_EN)
interface sc_popcount_collect_if #(
  parameter int NUM_LANES = 2,
  parameter int CNT_WIDTH = 8
);
  logic [NUM_LANES*(CNT_WIDTH+1)-1:0] res;
  logic                               res_valid;
  logic                               res_ready;
`ifdef SC_COLLECT_LEN_EN
  logic [CNT_WIDTH:0]                 res_len;

  modport master (output res, output res_valid, output res_len, input res_ready);
  modport slave  (input res, input res_valid, input res_len, output res_ready);
`else
  modport master (output res, output res_valid, input res_ready);
  modport slave  (input res, input res_valid, output res_ready);
`endif
endinterface

// File: rtl/sc_popcount_collect.sv
// rtl/sc_popcount_collect.sv - per-lane stochastic popcount with early-termination rescale (SC_COLLECT_LEN_EN adds period length)
module sc_popcount_collect #(
  parameter int NUM_LANES = 2,
  parameter int CNT_WIDTH = 8,
  parameter int SH_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NUM_LANES-1:0] bits,
  input  logic                 done_in,
  input  logic [SH_WIDTH-1:0]  trunc_sh,
  sc_popcount_collect_if.master res_if,
  output logic                 drop,
  input  logic                 drop_clr
);
  localparam int RW    = CNT_WIDTH + 1;
  localparam int EXT_W = RW + (1 << SH_WIDTH);

  typedef enum logic {WAIT_SYNC, RUN} state_t;

  state_t                  state_q, state_d;
  logic [RW-1:0]           acc_q [NUM_LANES];
  logic [RW-1:0]           acc_d [NUM_LANES];
  logic [NUM_LANES*RW-1:0] res_q, res_d, r;
  logic                    res_valid_q, res_valid_d;
  logic                    drop_q, drop_d;
  logic                    boundary, pop;
  logic [EXT_W-1:0]        ext;
`ifdef SC_COLLECT_LEN_EN
  logic [RW-1:0]           len_q, len_d, res_len_q, res_len_d;
`endif

  always_comb begin
    boundary    = (state_q == RUN) && en && done_in;
    pop         = res_valid_q && res_if.res_ready;
    state_d     = state_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    drop_d      = drop_q & ~drop_clr;
    r           = '0;
    ext         = '0;
`ifdef SC_COLLECT_LEN_EN
    len_d       = len_q;
    res_len_d   = res_len_q;
`endif
    // Shift in a wide field so any bit pushed past RW (including huge shifts) forces saturation.
    for (int i = 0; i < NUM_LANES; i++) begin
      acc_d[i]         = acc_q[i];
      ext              = EXT_W'(acc_q[i]) << trunc_sh;
      r[i*RW +: RW]    = (|ext[EXT_W-1:RW]) ? {RW{1'b1}} : ext[RW-1:0];
    end

    case (state_q)
      WAIT_SYNC: begin
        if (en && done_in) begin
          state_d = RUN;
          for (int i = 0; i < NUM_LANES; i++) acc_d[i] = RW'(bits[i]);
`ifdef SC_COLLECT_LEN_EN
          len_d = RW'(1);
`endif
        end
      end
      default: begin
        if (en) begin
          for (int i = 0; i < NUM_LANES; i++) begin
            if (done_in) acc_d[i] = RW'(bits[i]);
            else         acc_d[i] = (&acc_q[i]) ? acc_q[i] : acc_q[i] + RW'(bits[i]);
          end
`ifdef SC_COLLECT_LEN_EN
          if (done_in) len_d = RW'(1);
          else         len_d = (&len_q) ? len_q : len_q + RW'(1);
`endif
        end
      end
    endcase

    if (boundary) begin
      if (!res_valid_q || pop) begin
        res_d       = r;
        res_valid_d = 1'b1;
`ifdef SC_COLLECT_LEN_EN
        res_len_d   = len_q;
`endif
      end else begin
        drop_d = 1'b1;
      end
    end else if (pop) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= WAIT_SYNC;
      for (int i = 0; i < NUM_LANES; i++) acc_q[i] <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      drop_q      <= 1'b0;
`ifdef SC_COLLECT_LEN_EN
      len_q       <= '0;
      res_len_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      for (int i = 0; i < NUM_LANES; i++) acc_q[i] <= acc_d[i];
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      drop_q      <= drop_d;
`ifdef SC_COLLECT_LEN_EN
      len_q       <= len_d;
      res_len_q   <= res_len_d;
`endif
    end
  end

  assign res_if.res       = res_q;
  assign res_if.res_valid = res_valid_q;
  assign drop             = drop_q;
`ifdef SC_COLLECT_LEN_EN
  assign res_if.res_len   = res_len_q;
`endif
endmodule

// File: tb/tb_sc_popcount_collect.sv
// tb/tb_sc_popcount_collect.sv - directed self-checking bench for sc_popcount_collect (CNT_WIDTH=4)
module tb_sc_popcount_collect;
  localparam int NL = 2;
  localparam int CW = 4;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [NL-1:0] bits;
  logic          done_in;
  logic [SW-1:0] trunc_sh;
  logic          drop;
  logic          drop_clr;
  int            n_checks = 0;
  int            n_errors = 0;

  sc_popcount_collect_if #(.NUM_LANES(NL), .CNT_WIDTH(CW)) rif ();

  sc_popcount_collect #(.NUM_LANES(NL), .CNT_WIDTH(CW), .SH_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .en(en), .bits(bits), .done_in(done_in),
    .trunc_sh(trunc_sh), .res_if(rif), .drop(drop), .drop_clr(drop_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic e, input logic [NL-1:0] b, input logic d, input logic [SW-1:0] sh);
    en = e; bits = b; done_in = d; trunc_sh = sh;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lane(input int i);
    logic [NL*(CW+1)-1:0] v;
    v = rif.res;
    return 32'(v[i*(CW+1) +: CW+1]);
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; bits = '0; done_in = 1'b0; trunc_sh = '0;
    drop_clr = 1'b0; rif.res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(rif.res_valid), 0);
    check("rst_res", 32'(rif.res), 0);
    check("rst_drop", 32'(drop), 0);
    rst = 1'b0;

    // Full-length period: lane0 all ones, lane1 alternating, one disabled cycle in the middle.
    step(1, 2'b11, 0, 0);
    check("wait_no_valid", 32'(rif.res_valid), 0);
    step(1, 2'b00, 1, 0);
    check("sync_no_valid", 32'(rif.res_valid), 0);
    for (int i = 0; i < 16; i++) begin
      step(1, {(i % 2 == 0), 1'b1}, 0, 0);
      if (i == 7) step(0, 2'b11, 1, 0);
    end
    step(1, 2'b01, 1, 0);
    check("full_valid", 32'(rif.res_valid), 1);
    check("full_lane0", lane(0), 16);
    check("full_lane1", lane(1), 8);

    // Early-terminated: lane0 = 1 (boundary bit),1,0,1 shifted by 2.
    step(1, 2'b01, 0, 0);
    check("pop_valid_low", 32'(rif.res_valid), 0);
    check("pop_res_hold", lane(0), 16);
    step(1, 2'b00, 0, 0);
    step(1, 2'b01, 0, 0);
    step(1, 2'b11, 1, 2);
    check("early_lane0", lane(0), 12);
    check("early_lane1", lane(1), 0);
`ifdef SC_COLLECT_LEN_EN
    check("early_len", 32'(rif.res_len), 4);
`endif

    // Boundary bits 11 belong to the next all-ones period.
    for (int i = 0; i < 15; i++) step(1, 2'b11, 0, 0);
    step(1, 2'b11, 1, 0);
    check("bnd_lane0", lane(0), 16);
    check("bnd_lane1", lane(1), 16);

    // 16 ones shifted by 1 saturates.
    for (int i = 0; i < 15; i++) step(1, 2'b11, 0, 0);
    step(1, 2'b00, 1, 1);
    check("sat_lane0", lane(0), 31);
    check("sat_lane1", lane(1), 31);

    // Shift beyond CNT_WIDTH: nonzero saturates, zero stays zero.
    step(1, 2'b01, 0, 0);
    step(1, 2'b01, 0, 0);
    step(1, 2'b00, 1, 5);
    check("bigsh_lane0", lane(0), 31);
    check("bigsh_lane1", lane(1), 0);

    // Shift equal to CNT_WIDTH still fits.
    step(1, 2'b01, 0, 0);
    step(1, 2'b00, 1, 4);
    check("sh4_lane0", lane(0), 16);

    // Backpressure across boundaries.
    step(1, 2'b10, 0, 0);
    rif.res_ready = 1'b0;
    step(1, 2'b00, 1, 0);
    check("bp1_valid", 32'(rif.res_valid), 1);
    check("bp1_lane1", lane(1), 1);
    check("bp1_drop", 32'(drop), 0);
    step(1, 2'b01, 0, 0);
    step(1, 2'b00, 1, 0);
    check("bp2_drop", 32'(drop), 1);
    check("bp2_lane0_held", lane(0), 0);
    check("bp2_lane1_held", lane(1), 1);
    step(1, 2'b11, 0, 0);
    step(1, 2'b01, 0, 0);
    rif.res_ready = 1'b1;
    step(1, 2'b00, 1, 0);
    check("bp3_valid", 32'(rif.res_valid), 1);
    check("bp3_lane0", lane(0), 2);
    check("bp3_lane1", lane(1), 1);
    check("bp3_drop", 32'(drop), 1);
    rif.res_ready = 1'b0;
    drop_clr = 1'b1;
    step(1, 2'b00, 1, 0);
    check("clr_vs_set_drop", 32'(drop), 1);
    check("clr_vs_set_res", lane(0), 2);
    step(1, 2'b00, 0, 0);
    check("clr_drop", 32'(drop), 0);
    drop_clr = 1'b0;

    // Asynchronous reset mid-run with acc = 5 and a pending result.
    for (int i = 0; i < 5; i++) step(1, 2'b01, 0, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(rif.res_valid), 0);
    check("mid_rst_res", 32'(rif.res), 0);
    check("mid_rst_drop", 32'(drop), 0);
    #1;
    rst = 1'b0;
    rif.res_ready = 1'b1;
    step(1, 2'b01, 0, 0);
    step(1, 2'b11, 1, 0);
    check("resync_no_valid", 32'(rif.res_valid), 0);
    step(1, 2'b11, 0, 0);
    step(1, 2'b11, 0, 0);
    step(1, 2'b00, 1, 0);
    check("resync_valid", 32'(rif.res_valid), 1);
    check("resync_lane0", lane(0), 3);
    check("resync_lane1", lane(1), 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
